// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decoder handshake and execute redirect.
// The master modport is the fetch unit; the slave modport is memory/decoder/execute.
interface fetch_unit_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [7:0]      imem_rdata;
    logic            inst_valid;
    logic [7:0]      inst_out;
    logic [PC_W-1:0] inst_pc;
    logic            inst_ready;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem requests, FIFO_DEPTH instruction buffer, redirect flush.
// Latency: inst_valid 2 cycles after the request cycle with 1-cycle memory; optional stall_cnt via FETCH_PERF_CNT_EN.
// Backpressure: a request is issued only when a buffer slot is free, so a stalled decoder stops fetching.
module fetch_unit #(
    parameter int              PC_W       = 8,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]      state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt, pend_pc;
    logic [7:0]      fifo_inst [FIFO_DEPTH];
    logic [PC_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt;
    logic            push, pop, space_nxt, inst_valid_w, redirect;

    assign redirect     = bus.redirect_valid;
    assign inst_valid_w = (count != '0);
    assign pop          = inst_valid_w & bus.inst_ready;
    assign push         = (state == S_WAIT) & bus.imem_rvalid & ~redirect;

    // Space is judged on next-cycle occupancy so WAIT can chain straight into the next request.
    always_comb begin
        count_nxt = count;
        if (redirect) count_nxt = '0;
        else          count_nxt = count + CW'(push) - CW'(pop);
        space_nxt = (count_nxt < DEPTH_C);
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            S_IDLE: if (space_nxt) state_nxt = S_REQ;
            S_REQ: begin
                if (redirect) begin
                    if (bus.imem_gnt) state_nxt = S_DROP;
                end else if (bus.imem_gnt) begin
                    pc_nxt    = pc + PC_W'(1);
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) state_nxt = space_nxt ? S_REQ : S_IDLE;
                else if (redirect)   state_nxt = S_DROP;
            end
            S_DROP: if (bus.imem_rvalid) state_nxt = space_nxt ? S_REQ : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (redirect) pc_nxt = bus.redirect_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            pend_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if ((state == S_REQ) && bus.imem_gnt && !redirect) pend_pc <= pc;
        end
    end

    // Push into a full buffer with a concurrent pop is legal: the head is read before the slot is rewritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            count <= count_nxt;
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    fifo_inst[wr_ptr] <= bus.imem_rdata;
                    fifo_pc[wr_ptr]   <= pend_pc;
                    wr_ptr            <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    assign bus.imem_req   = (state == S_REQ);
    assign bus.imem_addr  = pc;
    assign bus.inst_valid = inst_valid_w;
    assign bus.inst_out   = fifo_inst[rd_ptr];
    assign bus.inst_pc    = fifo_pc[rd_ptr];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (bus.inst_ready && !inst_valid_w && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model returns addr^0xA5 after a programmable latency.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    logic gnt_en;
    int   lat;
    logic [7:0] q_pc [$];
    logic [7:0] q_in [$];
    int         q_cyc [$];
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] s0;
`endif

    fetch_unit_if #(.PC_W(8)) bus ();

    fetch_unit #(.PC_W(8), .FIFO_DEPTH(2), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Single-slot memory model, driven on the falling edge.
    initial begin
        int         cnt;
        logic       busy;
        logic [7:0] addr;
        busy = 1'b0;
        cnt  = 0;
        addr = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            bus.imem_rvalid = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
            end else if (busy) begin
                if (cnt == 1) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = addr ^ 8'hA5;
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
            bus.imem_gnt = gnt_en;
            if (rst_n && bus.imem_req && gnt_en) begin
                busy = 1'b1;
                cnt  = lat;
                addr = bus.imem_addr;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.inst_valid && bus.inst_ready) begin
                q_pc.push_back(bus.inst_pc);
                q_in.push_back(bus.inst_out);
                q_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = rdy;
        tick(2);
        q_pc.delete();
        q_in.delete();
        q_cyc.delete();
        rst_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [7:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick(1);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic wait_deliv(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while ((q_pc.size() < n) && (k < budget)) begin
            tick(1);
            k++;
        end
        tick(1);
        check(tag, 32'((q_pc.size() >= n) ? n : q_pc.size()), 32'(n));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        gnt_en   = 1'b1;
        lat      = 1;
        rst_n    = 1'b0;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        tick(2);

        // Reset values
        check("rst_req",   32'(bus.imem_req),   'h0);
        check("rst_addr",  32'(bus.imem_addr),  'h00);
        check("rst_valid", 32'(bus.inst_valid), 'h0);
        check("rst_inst",  32'(bus.inst_out),   'h00);
        check("rst_pc",    32'(bus.inst_pc),    'h00);
`ifdef FETCH_PERF_CNT_EN
        check("rst_stall", 32'(stall_cnt), 'h0);
`endif

        // Free-running fetch from reset
        do_reset(1'b1);
        tick(1);
        check("t1_req",    32'(bus.imem_req),   'h1);
        check("t1_addr",   32'(bus.imem_addr),  'h00);
        tick(1);
        check("t1_valid_e2", 32'(bus.inst_valid), 'h0);
        tick(1);
        check("t1_valid_e3", 32'(bus.inst_valid), 'h1);
        check("t1_head_pc",  32'(bus.inst_pc),    'h00);
        check("t1_head_in",  32'(bus.inst_out),   'hA5);
        wait_deliv("t1_count", 4, 40);
        check("t1_pc0", 32'(q_pc[0]), 'h00);
        check("t1_pc1", 32'(q_pc[1]), 'h01);
        check("t1_pc2", 32'(q_pc[2]), 'h02);
        check("t1_pc3", 32'(q_pc[3]), 'h03);
        check("t1_in1", 32'(q_in[1]), 'hA4);
        check("t1_in3", 32'(q_in[3]), 'hA6);
        check("t1_rate", 32'(q_cyc[2] - q_cyc[1]), 'h2);

        // Decoder stalled: buffer fills to two, fetch stops
        do_reset(1'b0);
        tick(10);
        check("t2_req",   32'(bus.imem_req),   'h0);
        check("t2_addr",  32'(bus.imem_addr),  'h02);
        check("t2_valid", 32'(bus.inst_valid), 'h1);
        check("t2_head",  32'(bus.inst_pc),    'h00);
        bus.inst_ready = 1'b1;
        wait_deliv("t2_count", 3, 30);
        check("t2_pc0", 32'(q_pc[0]), 'h00);
        check("t2_pc1", 32'(q_pc[1]), 'h01);
        check("t2_pc2", 32'(q_pc[2]), 'h02);
        check("t2_b2b", 32'(q_cyc[1] - q_cyc[0]), 'h1);

        // Redirect with a full buffer and a same-cycle pop
        do_reset(1'b0);
        tick(10);
        bus.inst_ready = 1'b1;
        redirect_to(8'h80);
        check("t3_flush", 32'(bus.inst_valid), 'h0);
        check("t3_req",   32'(bus.imem_req),   'h1);
        check("t3_addr",  32'(bus.imem_addr),  'h80);
        wait_deliv("t3_count", 2, 20);
        check("t3_pc0", 32'(q_pc[0]), 'h00);
        check("t3_pc1", 32'(q_pc[1]), 'h80);
        check("t3_in1", 32'(q_in[1]), 'h25);

        // Redirect while waiting on a 2-cycle response
        lat = 2;
        do_reset(1'b1);
        tick(2);
        check("t4_wait_req", 32'(bus.imem_req), 'h0);
        redirect_to(8'h40);
        check("t4_drop_req", 32'(bus.imem_req), 'h0);
        tick(1);
        check("t4_req",  32'(bus.imem_req),  'h1);
        check("t4_addr", 32'(bus.imem_addr), 'h40);
        wait_deliv("t4_count", 1, 20);
        check("t4_pc0", 32'(q_pc[0]), 'h40);
        check("t4_in0", 32'(q_in[0]), 'hE5);

        // Redirect in REQ without grant, plus stall counter
        lat    = 1;
        gnt_en = 1'b0;
        do_reset(1'b1);
        tick(1);
        check("t5_addr0", 32'(bus.imem_addr), 'h00);
        redirect_to(8'h10);
        check("t5_req",  32'(bus.imem_req),  'h1);
        check("t5_addr", 32'(bus.imem_addr), 'h10);
`ifdef FETCH_PERF_CNT_EN
        s0 = stall_cnt;
        tick(20);
        check("t5_stall20", 32'(stall_cnt - s0), 'd20);
        bus.inst_ready = 1'b0;
        s0 = stall_cnt;
        redirect_to(8'h10);
        tick(1);
        check("t5_stall_redir", 32'(stall_cnt), 32'(s0));
        bus.inst_ready = 1'b1;
`endif
        gnt_en = 1'b1;
        wait_deliv("t5_count", 1, 20);
        check("t5_pc0", 32'(q_pc[0]), 'h10);
        check("t5_in0", 32'(q_in[0]), 'hB5);

        // Redirect in REQ with grant, then PC wrap
        do_reset(1'b1);
        tick(1);
        redirect_to(8'hFE);
        check("t6_drop_req", 32'(bus.imem_req), 'h0);
        wait_deliv("t6_count", 4, 40);
        check("t6_pc0", 32'(q_pc[0]), 'hFE);
        check("t6_pc1", 32'(q_pc[1]), 'hFF);
        check("t6_pc2", 32'(q_pc[2]), 'h00);
        check("t6_pc3", 32'(q_pc[3]), 'h01);
        check("t6_in0", 32'(q_in[0]), 'h5B);
        check("t6_in1", 32'(q_in[1]), 'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
